capture_sequencer: RTL and testbench
====================================

# capture_sequencer

Single-clock controller that sequences one acquisition through the variable-width pre-trigger capture FIFO. It accepts host configuration and an arm command, then resets the FIFO and gates ADC samples into it. It holds off triggers until the pre-trigger window has filled, qualifies the trigger input (edge or level, with optional auto-trigger timeout), issues the FIFO trigger strobe and reports completion. It sits between the host register file/ADC front end and the FIFO write port.

## Interface
Parameters:
- DATA_WIDTH, 10, ADC sample width
- DATA_PER_ADDR, 3, samples per FIFO word; pre-trigger depth must be a multiple of this
- RST_CYCLES, 4, FIFO reset pulse length in clocks
- CNT_WIDTH, 32, width of all sample counters and configuration words

Ports (one clock, `clk`; reset `rst_n` is asynchronous, active-low):
- clk  in  1  system/ADC clock
- rst_n  in  1  async active-low reset
- arm  in  1  one-cycle start command
- abort  in  1  one-cycle cancel command
- cfg_presamples  in  CNT_WIDTH  pre-trigger depth in samples
- cfg_samples  in  CNT_WIDTH  total samples per capture
- cfg_timeout  in  CNT_WIDTH  auto-trigger timeout in clocks; 0 disables it
- cfg_trig_mode  in  2  0 rising edge, 1 falling edge, 2 high level, 3 low level
- adc_data  in  DATA_WIDTH  sample
- adc_valid  in  1  sample qualifier
- trig_in  in  1  synchronous trigger source
- fifo_rst  out  1  active-high FIFO reset
- fifo_wr_data  out  DATA_WIDTH  registered adc_data
- fifo_wr_ce  out  1  registered sample enable
- fifo_wr_trigger  out  1  trigger strobe, aligned with fifo_wr_ce
- fifo_number_samples  out  CNT_WIDTH  cfg_samples latched at arm
- fifo_circular_depth  out  CNT_WIDTH  cfg_presamples latched at arm
- fifo_wr_done  in  1  FIFO capture-complete flag
- busy  out  1  state is neither IDLE nor DONE
- done  out  1  sticky; set in DONE
- timed_out  out  1  sticky; capture was auto-triggered
- cfg_err  out  1  sticky; last arm was rejected
- state_o  out  3  current state encoding

## Operation
- States: IDLE(0), RESET(1), PREFILL(2), ARMED(3), CAPTURE(4), DONE(5).
- IDLE/DONE + arm: config checked. Reject if cfg_presamples mod DATA_PER_ADDR ≠ 0, or cfg_samples ≤ cfg_presamples, or cfg_samples = 0. On reject: set cfg_err, stay in the current state. On accept: latch cfg, clear done/timed_out/cfg_err, go to RESET.
- RESET: fifo_rst=1 for exactly RST_CYCLES clocks, then PREFILL.
- PREFILL: count adc_valid beats. When count = cfg_presamples → ARMED. With presamples=0 the block enters ARMED directly. Triggers are ignored here.
- ARMED: trig_prev is updated on every adc_valid beat in PREFILL and ARMED. A trigger fires on a valid beat where the condition holds: rising = ~trig_prev & trig_in; falling = trig_prev & ~trig_in; high/low = level. Timeout counter counts clocks in ARMED. Reaching cfg_timeout (≠0) forces a trigger on the next valid beat and sets timed_out. Trigger beat → CAPTURE.
- CAPTURE: wait for fifo_wr_done = 1 → DONE.
- DONE: gating off; wait for arm.
- abort in any state except IDLE → IDLE. fifo_wr_ce is forced to 0 from the next cycle. done is not set. fifo_rst pulses for RST_CYCLES. abort beats arm in the same cycle.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- fifo_wr_data/fifo_wr_ce are adc_data/adc_valid delayed exactly 1 clock. fifo_wr_ce is gated by the state (PREFILL, ARMED or CAPTURE) at the input cycle.
- fifo_wr_trigger = 1 for exactly one clock, on the registered copy of the trigger beat. It is never asserted without fifo_wr_ce.
- fifo_number_samples/fifo_circular_depth change only on an accepted arm, and are valid from the first RESET cycle.
- Counters saturate and never wrap. The timeout compare uses equality on a saturating counter.
- Trigger and timeout expiring on the same beat: counts as a real trigger; timed_out stays 0.
- rst_n asserted mid-capture: immediate return to reset values, no fifo_rst pulse.

## Structure
- Package capture_pkg holds the state enum, the trig_mode encodings and the CNT_WIDTH default.
- One natural sub-module, trig_qualifier: trig_prev register, mode decode, timeout counter, fire/timed_out outputs. The top holds the FSM, config latch, prefill counter and output registers.

## Test plan
- presamples=6, samples=30, rising mode, adc_valid constant, trig 0→1 at sample 20 → one fifo_wr_trigger on sample 20's registered beat, done after fifo_wr_done.
- Trigger edge during PREFILL (presamples=9, edge at sample 3) → ignored. State stays PREFILL until 9 beats, no fifo_wr_trigger.
- timeout=50, trig_in held 0 → fifo_wr_trigger on the first valid beat at ARMED cycle 50, timed_out=1.
- Arm with presamples=7 (DATA_PER_ADDR=3) → cfg_err=1, state IDLE, no fifo_rst.
- abort in CAPTURE → fifo_wr_ce=0 next cycle, fifo_rst high 4 clocks, state IDLE, done=0.
- rst_n low in ARMED with adc_valid=1 → all outputs 0 asynchronously. The next arm runs a normal sequence.

Source files
------------

// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding, trigger modes and counter width for the capture sequencer
package capture_pkg;
    localparam int CNT_WIDTH_DEF = 32;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_PREFILL = 3'd2,
        ST_ARMED   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;
    localparam logic [1:0] TRIG_RISE = 2'd0;
    localparam logic [1:0] TRIG_FALL = 2'd1;
    localparam logic [1:0] TRIG_HIGH = 2'd2;
    localparam logic [1:0] TRIG_LOW  = 2'd3;
endpackage

// File: rtl/capture_sequencer_trig_qualifier.sv
// trig_qualifier: edge/level trigger decode with auto-trigger timeout
//   clk/rst_n       clock, asynchronous active-low reset
//   clear           forget the previous trigger level (start of a capture)
//   track           valid beat on which the previous trigger level is sampled
//   armed/valid     trigger window open / sample beat present
//   trig_in/mode    trigger source and mode (rise, fall, high, low)
//   timeout         clocks in the window before a forced trigger; 0 disables
//   fire            trigger beat; timeout_fire marks a beat forced only by the timeout
module trig_qualifier
    import capture_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 track,
    input  logic                 armed,
    input  logic                 valid,
    input  logic                 trig_in,
    input  logic [1:0]           mode,
    input  logic [CNT_WIDTH-1:0] timeout,
    output logic                 fire,
    output logic                 timeout_fire
);
    logic                 trig_prev;
    logic                 cond;
    logic                 expired;
    logic [CNT_WIDTH-1:0] to_cnt;

    always_comb begin
        cond = mode == TRIG_RISE ? !trig_prev && trig_in :
               mode == TRIG_FALL ? trig_prev && !trig_in :
               mode == TRIG_HIGH ? trig_in : !trig_in;
    end

    // the counter parks at the timeout value, so expiry stays pending until a valid beat
    assign expired      = timeout != '0 && to_cnt == timeout;
    assign fire         = armed && valid && (cond || expired);
    assign timeout_fire = armed && valid && expired && !cond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_prev <= 1'b0;
            to_cnt    <= '0;
        end else begin
            trig_prev <= clear ? 1'b0 : track ? trig_in : trig_prev;
            to_cnt    <= !armed ? '0 :
                         (to_cnt == timeout || to_cnt == '1) ? to_cnt : to_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: sequences one pre-trigger acquisition through the capture FIFO
//   clk/rst_n                   clock, asynchronous active-low reset
//   arm/abort                   one-cycle host commands (abort wins)
//   cfg_*                       capture configuration, latched on an accepted arm
//   adc_data/adc_valid/trig_in  sample stream and trigger source
//   fifo_*                      FIFO write-port controls; fifo_wr_done is the completion flag
//   busy/done/timed_out/cfg_err/state_o  status
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int DATA_WIDTH    = 10,
    parameter int DATA_PER_ADDR = 3,
    parameter int RST_CYCLES    = 4,
    parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  cfg_presamples,
    input  logic [CNT_WIDTH-1:0]  cfg_samples,
    input  logic [CNT_WIDTH-1:0]  cfg_timeout,
    input  logic [1:0]            cfg_trig_mode,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  adc_valid,
    input  logic                  trig_in,
    output logic                  fifo_rst,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_wr_ce,
    output logic                  fifo_wr_trigger,
    output logic [CNT_WIDTH-1:0]  fifo_number_samples,
    output logic [CNT_WIDTH-1:0]  fifo_circular_depth,
    input  logic                  fifo_wr_done,
    output logic                  busy,
    output logic                  done,
    output logic                  timed_out,
    output logic                  cfg_err,
    output logic [2:0]            state_o
);
    localparam int RW = $clog2(RST_CYCLES + 1);

    state_t               state, next_state;
    logic [RW-1:0]        rst_cnt;
    logic [CNT_WIDTH-1:0] pre_cnt;
    logic [CNT_WIDTH-1:0] timeout_q;
    logic [1:0]           mode_q;
    logic                 idle_like, cfg_ok, arm_try, accept, abort_go, gate, last_pre;
    logic                 q_fire, q_timeout_fire, trig_fire;

    assign idle_like = state == ST_IDLE || state == ST_DONE;
    assign cfg_ok    = (cfg_presamples % CNT_WIDTH'(DATA_PER_ADDR)) == '0 && cfg_samples > cfg_presamples;
    assign arm_try   = idle_like && arm && !abort;
    assign accept    = arm_try && cfg_ok;
    assign abort_go  = abort && state != ST_IDLE;
    assign gate      = (state == ST_PREFILL || state == ST_ARMED || state == ST_CAPTURE) && !abort;
    assign last_pre  = adc_valid && pre_cnt + CNT_WIDTH'(1) == fifo_circular_depth;
    assign trig_fire = q_fire && !abort;
    assign fifo_rst  = rst_cnt != '0;
    assign busy      = !idle_like;
    assign state_o   = state;

    trig_qualifier #(.CNT_WIDTH(CNT_WIDTH)) u_trig (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (state == ST_RESET),
        .track        (adc_valid && (state == ST_PREFILL || state == ST_ARMED)),
        .armed        (state == ST_ARMED),
        .valid        (adc_valid),
        .trig_in      (trig_in),
        .mode         (mode_q),
        .timeout      (timeout_q),
        .fire         (q_fire),
        .timeout_fire (q_timeout_fire)
    );

    always_comb begin
        next_state = state;
        if (abort_go) next_state = ST_IDLE;
        else case (state)
            ST_IDLE, ST_DONE: if (accept) next_state = ST_RESET;
            ST_RESET:   if (rst_cnt == RW'(1)) next_state = fifo_circular_depth == '0 ? ST_ARMED : ST_PREFILL;
            ST_PREFILL: if (last_pre) next_state = ST_ARMED;
            ST_ARMED:   if (trig_fire) next_state = ST_CAPTURE;
            ST_CAPTURE: if (fifo_wr_done) next_state = ST_DONE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            rst_cnt             <= '0;
            pre_cnt             <= '0;
            timeout_q           <= '0;
            mode_q              <= '0;
            fifo_wr_data        <= '0;
            fifo_wr_ce          <= 1'b0;
            fifo_wr_trigger     <= 1'b0;
            fifo_number_samples <= '0;
            fifo_circular_depth <= '0;
            done                <= 1'b0;
            timed_out           <= 1'b0;
            cfg_err             <= 1'b0;
        end else begin
            state           <= next_state;
            fifo_wr_data    <= adc_data;
            fifo_wr_ce      <= adc_valid && gate;
            fifo_wr_trigger <= trig_fire;
            // one counter times both the RESET state and the post-abort FIFO reset pulse
            rst_cnt         <= (accept || abort_go) ? RW'(RST_CYCLES) : rst_cnt != '0 ? rst_cnt - RW'(1) : rst_cnt;
            pre_cnt         <= accept ? '0 :
                               (state == ST_PREFILL && adc_valid && pre_cnt != '1) ? pre_cnt + CNT_WIDTH'(1) : pre_cnt;
            if (accept) begin
                fifo_number_samples <= cfg_samples;
                fifo_circular_depth <= cfg_presamples;
                timeout_q           <= cfg_timeout;
                mode_q              <= cfg_trig_mode;
            end
            done      <= accept ? 1'b0 : (state == ST_CAPTURE && next_state == ST_DONE) ? 1'b1 : done;
            timed_out <= accept ? 1'b0 : timed_out || (q_timeout_fire && !abort);
            cfg_err   <= accept ? 1'b0 : (arm_try && !cfg_ok) ? 1'b1 : cfg_err;
        end
    end
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: randomized self-checking bench against a timeline model of the capture sequence
module tb_capture_sequencer;
    localparam int DW = 10, R = 4, CW = 32, NMAX = 1024;

    logic clk = 0, rst_n = 0, arm = 0, abort = 0, adc_valid = 0, trig_in = 0, fifo_wr_done = 0;
    logic [CW-1:0] cfg_presamples = 0, cfg_samples = 0, cfg_timeout = 0;
    logic [1:0] cfg_trig_mode = 0;
    logic [DW-1:0] adc_data = 0;
    logic fifo_rst, fifo_wr_ce, fifo_wr_trigger, busy, done, timed_out, cfg_err;
    logic [DW-1:0] fifo_wr_data;
    logic [CW-1:0] fifo_number_samples, fifo_circular_depth;
    logic [2:0] state_o;
    logic [DW+8:0] obs;
    int passed = 0, total = 0;
    bit v[NMAX];
    bit t[NMAX];
    logic [DW-1:0] dat[NMAX];

    capture_sequencer #(.DATA_WIDTH(DW), .DATA_PER_ADDR(3), .RST_CYCLES(R), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
        .cfg_presamples(cfg_presamples), .cfg_samples(cfg_samples), .cfg_timeout(cfg_timeout),
        .cfg_trig_mode(cfg_trig_mode), .adc_data(adc_data), .adc_valid(adc_valid), .trig_in(trig_in),
        .fifo_rst(fifo_rst), .fifo_wr_data(fifo_wr_data), .fifo_wr_ce(fifo_wr_ce),
        .fifo_wr_trigger(fifo_wr_trigger), .fifo_number_samples(fifo_number_samples),
        .fifo_circular_depth(fifo_circular_depth), .fifo_wr_done(fifo_wr_done), .busy(busy),
        .done(done), .timed_out(timed_out), .cfg_err(cfg_err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign obs = {state_o, busy, fifo_rst, fifo_wr_ce, fifo_wr_trigger, done, timed_out, fifo_wr_data};

    // state expected in cycle c of a capture armed in cycle 0
    function automatic logic [2:0] st_at(input int c, input int xa, input int a, input int tt, input int d);
        return c > xa ? 3'd0 : c <= R ? 3'd1 : c < a ? 3'd2 : c <= tt ? 3'd3 : c <= d ? 3'd4 : 3'd5;
    endfunction

    task automatic fill_rand(input int vp);
        t[0] = 1'($urandom);
        for (int c = 0; c < NMAX; c++) begin
            v[c] = ($urandom % 100) < vp;
            if (c > 0) t[c] = ($urandom % 4 == 0) ? !t[c-1] : t[c-1];
        end
    endtask

    // Arms in cycle 0 (entered at posedge+1); x is the abort cycle or -1; fifo_wr_done pulses dd cycles into CAPTURE.
    task automatic run_capture(input string name, input int p, input int s, input int to,
                               input int mode, input int x, input int dd);
        int a, tt, d, xa, len, k;
        bit prev, tmo, cond;
        logic [2:0] es, ep;
        logic [DW+8:0] exp;
        xa = x < 0 ? 32'h3fff_ffff : x;
        a = R + 1; prev = 0; k = 0;
        if (p > 0)
            for (int c = R + 1; c < NMAX; c++)
                if (v[c]) begin
                    prev = t[c]; k++;
                    if (k == p) begin a = c + 1; break; end
                end
        tt = NMAX; tmo = 0;
        for (int c = a; c < NMAX; c++)
            if (v[c]) begin
                cond = mode == 0 ? (!prev && t[c]) : mode == 1 ? (prev && !t[c]) : mode == 2 ? t[c] : !t[c];
                if (cond || (to != 0 && c - a >= to)) begin tt = c; tmo = !cond; break; end
                prev = t[c];
            end
        d = tt + 1 + dd;
        len = (x >= 0 ? x + R : d) + 4;
        if (len > NMAX - 1) len = NMAX - 1;
        cfg_presamples = CW'(p); cfg_samples = CW'(s); cfg_timeout = CW'(to); cfg_trig_mode = 2'(mode);
        for (int c = 0; c < len; c++) begin
            arm = c == 0; abort = c == x; adc_valid = v[c]; trig_in = t[c]; fifo_wr_done = c == d;
            dat[c] = DW'($urandom); adc_data = dat[c];
            if (c == 1) begin cfg_presamples = $urandom; cfg_samples = $urandom; cfg_timeout = $urandom; end
            @(negedge clk);
            if (c >= 1) begin
                es = st_at(c, xa, a, tt, d);
                ep = st_at(c - 1, xa, a, tt, d);
                exp = {es, es != 3'd0 && es != 3'd5,
                       (c <= R && c <= xa) || (c > xa && c <= xa + R),
                       v[c-1] && (ep == 3'd2 || ep == 3'd3 || ep == 3'd4) && (c - 1 != x),
                       (c - 1 == tt) && (tt < xa),
                       c > d && d < xa,
                       tmo && c > tt && tt < xa,
                       dat[c-1]};
                total++;
                if (obs !== exp) $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs, exp);
                else passed++;
            end
            @(posedge clk); #1;
        end
        arm = 0; abort = 0; fifo_wr_done = 0;
        total++;
        if ({fifo_number_samples, fifo_circular_depth, cfg_err} !== {CW'(s), CW'(p), 1'b0})
            $display("FAIL %s cfg latch: got %0d/%0d/%b expected %0d/%0d/0", name,
                     fifo_number_samples, fifo_circular_depth, cfg_err, s, p);
        else passed++;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({obs, fifo_number_samples, fifo_circular_depth} !== '0) $display("FAIL reset: got %h expected 0", obs);
        else passed++;
        rst_n = 1;
        @(negedge clk);
        total++;
        if (obs !== '0) $display("FAIL reset_release: got %h expected 0", obs);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_cfg_err;
        int bp[3] = '{7, 6, 0};
        int bs[3] = '{30, 6, 0};
        for (int i = 0; i < 3; i++) begin
            cfg_presamples = CW'(bp[i]); cfg_samples = CW'(bs[i]); arm = 1;
            @(posedge clk); #1;
            arm = 0;
            total++;
            if ({state_o, cfg_err, fifo_rst, fifo_circular_depth} !== {3'd0, 1'b1, 1'b0, CW'(0)})
                $display("FAIL cfg_err_%0d: got st=%0d err=%b rst=%b depth=%0d expected st=0 err=1 rst=0 depth=0",
                         i, state_o, cfg_err, fifo_rst, fifo_circular_depth);
            else passed++;
            @(posedge clk); #1;
            total++;
            if ({state_o, fifo_rst} !== 4'b0000) $display("FAIL cfg_err_hold_%0d: got %b expected 0000", i, {state_o, fifo_rst});
            else passed++;
        end
    endtask

    task automatic test_basic;
        for (int c = 0; c < NMAX; c++) begin v[c] = 1; t[c] = c >= R + 1 + 20; end
        run_capture("basic", 6, 30, 0, 0, -1, 7);
        cfg_presamples = 7; cfg_samples = 30; arm = 1;
        @(posedge clk); #1;
        arm = 0;
        total++;
        if ({state_o, cfg_err, done} !== {3'd5, 1'b1, 1'b1})
            $display("FAIL reject_in_done: got st=%0d err=%b done=%b expected st=5 err=1 done=1", state_o, cfg_err, done);
        else passed++;
    endtask

    task automatic test_prefill_ignore;
        for (int c = 0; c < NMAX; c++) begin
            v[c] = 1;
            t[c] = (c == R + 1 + 3) || (c == R + 1 + 4) || (c >= R + 1 + 15);
        end
        run_capture("prefill_ignore", 9, 40, 0, 0, -1, 3);
    endtask

    task automatic test_timeout;
        fill_rand(60);
        for (int c = 0; c < NMAX; c++) t[c] = 0;
        run_capture("timeout", 3, 20, 50, 0, -1, 2);
        total++;
        if (timed_out !== 1'b1) $display("FAIL timeout_flag: got %b expected 1", timed_out);
        else passed++;
        for (int c = 0; c < NMAX; c++) begin v[c] = 1; t[c] = c >= R + 1 + 10; end
        run_capture("timeout_tie", 0, 12, 10, 2, -1, 2);
        total++;
        if (timed_out !== 1'b0) $display("FAIL timeout_tie_flag: got %b expected 0", timed_out);
        else passed++;
    endtask

    task automatic test_abort;
        for (int c = 0; c < NMAX; c++) begin v[c] = 1; t[c] = c >= R + 1 + 20; end
        run_capture("abort_capture", 6, 30, 0, 0, R + 1 + 20 + 3, 20);
        total++;
        if ({state_o, done} !== 4'b0000) $display("FAIL abort_final: got st=%0d done=%b expected st=0 done=0", state_o, done);
        else passed++;
    endtask

    task automatic test_async_reset;
        cfg_presamples = 3; cfg_samples = 20; cfg_timeout = 0; cfg_trig_mode = 2;
        trig_in = 0; adc_valid = 1; arm = 1;
        @(posedge clk); #1;
        arm = 0;
        repeat (R + 5) @(posedge clk);
        #1;
        total++;
        if (state_o !== 3'd3) $display("FAIL async_pre_armed: got st=%0d expected 3", state_o);
        else passed++;
        #2 rst_n = 0;
        #1;
        total++;
        if ({obs, fifo_number_samples, fifo_circular_depth} !== '0) $display("FAIL async_reset: got %h expected 0", obs);
        else passed++;
        @(posedge clk); #2 rst_n = 1;
        @(negedge clk);
        total++;
        if (obs !== '0) $display("FAIL async_release: got %h expected 0", obs);
        else passed++;
        @(posedge clk); #1;
        fill_rand(70);
        run_capture("after_async", 3, 25, 40, 2, -1, 4);
    endtask

    task automatic test_back_to_back;
        int p, x;
        for (int i = 0; i < 30; i++) begin
            fill_rand($urandom_range(30, 100));
            p = 3 * $urandom_range(0, 5);
            x = $urandom_range(0, 4) == 0 ? $urandom_range(1, 60) : -1;
            run_capture($sformatf("random_%0d", i), p, p + $urandom_range(1, 40),
                        $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 60),
                        $urandom_range(0, 3), x, $urandom_range(0, 10));
        end
    endtask

    initial begin
        test_reset;
        test_cfg_err;
        test_basic;
        test_prefill_ignore;
        test_timeout;
        test_abort;
        test_async_reset;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
